// File: rtl/waverforms_mul_pipe_sat.sv
// Pipelined signed x unsigned fixed-point multiplier: round half up, shift by SHIFT, range-limit.
// Define WAVERFORMS_MUL_SAT_EN to clamp out-of-range results; otherwise they wrap.
module waverforms_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32,
  parameter int SHIFT      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic        [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic        [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int W      = din0_WIDTH + din1_WIDTH;
  localparam int HI_W   = W - dout_WIDTH + 2;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W:0] RND = (SHIFT > 0) ? ({{W{1'b0}}, 1'b1} << RND_SH) : '0;

  // One guard bit above the product keeps the rounding add from overflowing.
  function automatic logic signed [W:0] rnd_shift(input logic signed [W-1:0] p);
    logic signed [W:0] r;
    r = $signed({p[W-1], p}) + RND;
    return r >>> SHIFT;
  endfunction

  // In range only when every bit from the output sign bit upward agrees.
  function automatic logic range_ovf(input logic [HI_W-1:0] hi);
    return !((&hi) || !(|hi));
  endfunction

`ifdef WAVERFORMS_MUL_SAT_EN
  function automatic logic [dout_WIDTH-1:0] sat_clamp(input logic                  neg,
                                                      input logic                  over,
                                                      input logic [dout_WIDTH-1:0] wrap);
    logic [dout_WIDTH-1:0] res;
    res = wrap;
    if (over) res = neg ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
    return res;
  endfunction
`endif

  logic signed [din0_WIDTH-1:0] mul_a;
  logic        [din1_WIDTH-1:0] mul_b;
  logic                         mul_vld;

  generate
    if (NUM_STAGE == 1) begin : g_in_comb
      assign mul_a   = din0;
      assign mul_b   = din1;
      assign mul_vld = in_valid;
    end else begin : g_in_reg
      logic signed [din0_WIDTH-1:0] din0_p0;
      logic        [din1_WIDTH-1:0] din1_p0;
      logic                         vld_p0;

      // ---- stage 1: operand capture ----
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          din0_p0 <= '0;
          din1_p0 <= '0;
          vld_p0  <= 1'b0;
        end else if (ce) begin
          din0_p0 <= din0;
          din1_p0 <= din1;
          vld_p0  <= in_valid;
        end
      end

      assign mul_a   = din0_p0;
      assign mul_b   = din1_p0;
      assign mul_vld = vld_p0;
    end
  endgenerate

  logic signed [W-1:0] mul_a_ext;
  logic signed [W-1:0] mul_b_ext;
  logic signed [W-1:0] prod_c;

  // Unsigned operand is zero-extended so it can never be read as negative.
  assign mul_a_ext = W'(mul_a);
  assign mul_b_ext = W'(mul_b);
  assign prod_c    = mul_a_ext * mul_b_ext;

  logic signed [W-1:0] res_prod;
  logic                res_vld;

  generate
    if (NUM_STAGE <= 2) begin : g_prod_comb
      assign res_prod = prod_c;
      assign res_vld  = mul_vld;
    end else if (NUM_STAGE == 3) begin : g_prod_1
      logic signed [W-1:0] prod_p1;
      logic                vld_p1;

      // ---- stage 2: full-precision product ----
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prod_p1 <= '0;
          vld_p1  <= 1'b0;
        end else if (ce) begin
          prod_p1 <= prod_c;
          vld_p1  <= mul_vld;
        end
      end

      assign res_prod = prod_p1;
      assign res_vld  = vld_p1;
    end else begin : g_prod_2
      logic signed [W-1:0] prod_p1;
      logic signed [W-1:0] prod_p2;
      logic                vld_p1;
      logic                vld_p2;

      // ---- stages 2-3: product, then retimed product ----
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prod_p1 <= '0;
          prod_p2 <= '0;
          vld_p1  <= 1'b0;
          vld_p2  <= 1'b0;
        end else if (ce) begin
          prod_p1 <= prod_c;
          prod_p2 <= prod_p1;
          vld_p1  <= mul_vld;
          vld_p2  <= vld_p1;
        end
      end

      assign res_prod = prod_p2;
      assign res_vld  = vld_p2;
    end
  endgenerate

  logic signed [W:0]           s_c;
  logic                        ovf_c;
  logic        [dout_WIDTH-1:0] dout_c;

  assign s_c   = rnd_shift(res_prod);
  assign ovf_c = range_ovf(s_c[W:dout_WIDTH-1]);
`ifdef WAVERFORMS_MUL_SAT_EN
  assign dout_c = sat_clamp(s_c[W], ovf_c, s_c[dout_WIDTH-1:0]);
`else
  assign dout_c = s_c[dout_WIDTH-1:0];
`endif

  // ---- last stage: rounded, shifted, range-limited result ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= res_vld;
      dout      <= dout_c;
      ovf       <= ovf_c;
    end
  end

endmodule
